// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - shared types and constants for the QED commit tracker
package qed_pkg;

    localparam int QED_CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        QED_IDLE  = 2'd0,
        QED_PULSE = 2'd1,
        QED_TRACK = 2'd2
    } qed_state_e;

endpackage

// File: rtl/qed_commit_tracker_if.sv
// rtl/qed_commit_tracker_if.sv - issue/retire observation and commit status bundle
interface qed_commit_tracker_if #(
    parameter int CNT_W = qed_pkg::QED_CNT_W_DEFAULT
);
    logic             instr_valid;
    logic             instr_is_dup;
    logic             retire_valid;
    logic             retire_is_dup;
    logic             sif_req;
    logic             sif_commit;
    logic             sif_commit_pulsed;
    logic             qed_check_valid;
    logic [CNT_W-1:0] qed_num_orig;
    logic [CNT_W-1:0] qed_num_dup;
    logic             qed_err;

    modport master (
        output instr_valid, instr_is_dup, retire_valid, retire_is_dup, sif_req,
        input  sif_commit, sif_commit_pulsed, qed_check_valid,
               qed_num_orig, qed_num_dup, qed_err
    );

    modport slave (
        input  instr_valid, instr_is_dup, retire_valid, retire_is_dup, sif_req,
        output sif_commit, sif_commit_pulsed, qed_check_valid,
               qed_num_orig, qed_num_dup, qed_err
    );
endinterface

// File: rtl/qed_sat_counter.sv
// rtl/qed_sat_counter.sv - up/down counter that clamps at both ends and flags it
module qed_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat,
    output logic         unf
);
    localparam logic [W-1:0] MAX = '1;

    logic up;
    logic down;

    assign up   = inc & ~dec;
    assign down = dec & ~inc;

    // sat fires in the same cycle the count lands on (or pushes against) MAX
    assign sat = ~clr & up & (count >= MAX - W'(1));
    assign unf = ~clr & down & (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (up && count != MAX) begin
            count <= count + W'(1);
        end else if (down && count != '0) begin
            count <= count - W'(1);
        end
    end
endmodule

// File: rtl/qed_commit_tracker.sv
// rtl/qed_commit_tracker.sv - SQED commit point and retirement balance tracker; option QED_INFLIGHT_CHECK_EN
module qed_commit_tracker
    import qed_pkg::*;
#(
    parameter int CNT_W = QED_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qed_commit_tracker_if.slave  bus
);
`ifdef QED_INFLIGHT_CHECK_EN
    localparam bit INFLIGHT_CHK = 1'b1;
`else
    localparam bit INFLIGHT_CHK = 1'b0;
`endif

    qed_state_e       state_q;
    qed_state_e       state_d;
    logic             track_en;
    logic [CNT_W-1:0] orig_cnt;
    logic [CNT_W-1:0] dup_cnt;
    logic [CNT_W-1:0] inflight_cnt;
    logic             orig_sat, orig_unf;
    logic             dup_sat, dup_unf;
    logic             inf_sat, inf_unf;
    logic             err_q;
    logic             inflight_ok;

    // Orig/dup counts only run from the pulse cycle onward; IDLE pins them to zero
    assign track_en = (state_q != QED_IDLE);

    qed_sat_counter #(.W(CNT_W)) u_orig (
        .clk(clk), .rst_n(rst_n), .clr(~track_en),
        .inc(bus.retire_valid & ~bus.retire_is_dup), .dec(1'b0),
        .count(orig_cnt), .sat(orig_sat), .unf(orig_unf)
    );

    qed_sat_counter #(.W(CNT_W)) u_dup (
        .clk(clk), .rst_n(rst_n), .clr(~track_en),
        .inc(bus.retire_valid & bus.retire_is_dup), .dec(1'b0),
        .count(dup_cnt), .sat(dup_sat), .unf(dup_unf)
    );

    qed_sat_counter #(.W(CNT_W)) u_inflight (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .inc(bus.instr_valid), .dec(bus.retire_valid),
        .count(inflight_cnt), .sat(inf_sat), .unf(inf_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= QED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            QED_IDLE:  if (bus.sif_req && inflight_cnt == '0 && !bus.instr_valid)
                           state_d = QED_PULSE;
            QED_PULSE: state_d = QED_TRACK;
            QED_TRACK: state_d = QED_TRACK;
            default:   state_d = QED_IDLE;
        endcase
    end

    always_comb begin
        bus.sif_commit_pulsed = 1'b0;
        bus.sif_commit        = 1'b0;
        case (state_q)
            QED_PULSE: bus.sif_commit_pulsed = 1'b1;
            QED_TRACK: bus.sif_commit        = 1'b1;
            default:   ;
        endcase
    end

    // orig/dup underflow cannot occur (never decremented) but is kept in the error sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | orig_sat | dup_sat | inf_sat | orig_unf | dup_unf
                   | (INFLIGHT_CHK & inf_unf);
        end
    end

    assign inflight_ok = ~INFLIGHT_CHK | (inflight_cnt == '0);

    assign bus.qed_num_orig    = orig_cnt;
    assign bus.qed_num_dup     = dup_cnt;
    assign bus.qed_err         = err_q;
    assign bus.qed_check_valid = bus.sif_commit && (orig_cnt == dup_cnt)
                               && (orig_cnt != '0) && !err_q && inflight_ok;
endmodule

// File: doc/qed_commit_tracker.md
# qed_commit_tracker

Commit-point and retirement bookkeeping stage feeding the SQED property layer. Sits between the QED instruction duplicator/shim and the formal checker. Observes instruction issue and retirement on the core. Generates:
- the single-cycle symbolic commit pulse (`sif_commit_pulsed`);
- the post-commit level (`sif_commit`);
- original/duplicate retirement counts;
- `qed_check_valid`, the qualifier under which register and memory QED-consistency assertions are evaluated.

## Interface
Parameters:
- `CNT_W`, 8: width of orig/dup/in-flight counters.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  one instruction accepted by core fetch this cycle.
- `instr_is_dup`  in  1  accepted instruction is a QED duplicate; qualified by `instr_valid`.
- `retire_valid`  in  1  one instruction retired (writeback/store complete) this cycle.
- `retire_is_dup`  in  1  retired instruction is a duplicate; qualified by `retire_valid`.
- `sif_req`  in  1  request to take the commit point; free input under formal.
- `sif_commit`  out  1  high from the cycle after the pulse onward, until reset.
- `sif_commit_pulsed`  out  1  one-cycle commit pulse (T_C).
- `qed_check_valid`  out  1  orig/dup retire counts balanced and nonzero; check is legal.
- `qed_num_orig`  out  CNT_W  originals retired since T_C.
- `qed_num_dup`  out  CNT_W  duplicates retired since T_C.
- `qed_err`  out  1  sticky: counter saturation or in-flight underflow.

## Operation
FSM states: IDLE, PULSE, TRACK.
- IDLE:
  - Counters `qed_num_orig`/`qed_num_dup` held at 0.
  - In-flight counter updates normally.
  - `sif_req && inflight==0 && !instr_valid` moves to PULSE. Otherwise stays in IDLE.
- PULSE:
  - `sif_commit_pulsed`=1 for exactly one cycle.
  - Orig/dup counters are 0 on entry. Retires in this cycle are counted.
  - Unconditionally moves to TRACK.
- TRACK:
  - `sif_commit`=1.
  - `retire_valid` increments `qed_num_dup` if `retire_is_dup`, else `qed_num_orig`.
  - Stays in TRACK until reset. `sif_req` is ignored in PULSE and TRACK.
- In-flight counter:
  - +1 on `instr_valid`, −1 on `retire_valid`.
  - Both in the same cycle: no change.
  - Retire while at 0: clamp at 0, set `qed_err`.
- Saturation:
  - Any counter reaching 2^CNT_W−1 holds there and sets `qed_err`.
- `qed_check_valid` (combinational from registered state) = `sif_commit && qed_num_orig==qed_num_dup && qed_num_orig!=0 && !qed_err`, plus the in-flight term under Configuration.
- `qed_err` is sticky until reset.

## Timing
- Reset (async assert, synchronous deassert by the integrator): state=IDLE; all counters 0; every output 0.
- A retire at cycle t is visible on the counts at t+1. `qed_check_valid` can rise at t+1.
- `sif_req` at t (conditions met) gives `sif_commit_pulsed`=1 at t+1 and `sif_commit`=1 from t+2.
- `sif_commit` and `sif_commit_pulsed` are never high together.
- Reset mid-TRACK: outputs drop asynchronously. Tracking restarts from IDLE.

## Configuration
- `QED_INFLIGHT_CHECK_EN` defined:
  - `qed_check_valid` additionally requires in-flight count == 0.
  - In-flight underflow feeds `qed_err`.
- Undefined:
  - In-flight counter is still kept for the IDLE→PULSE condition.
  - `qed_check_valid` ignores it.
  - Underflow does not set `qed_err`.

## Structure
- Package `qed_pkg`: FSM state enum (`QED_IDLE`, `QED_PULSE`, `QED_TRACK`) and default `CNT_W` constant.
- Sub-module `qed_sat_counter`:
  - Parameterised up/down saturating counter with clear, increment, decrement and saturation/underflow flags.
  - Instantiated three times: orig, dup, in-flight.
- Top holds the FSM and output logic.

## Test plan
- Reset mid-TRACK with counts 3/3 → all outputs 0 immediately; state IDLE; `sif_req` needs `inflight==0` again.
- Issue 2, retire 2, then `sif_req` at cycle 10 → pulse at 11, `sif_commit` from 12; `sif_req` at 15 has no effect.
- After T_C, retire orig ×3 then dup ×3 on cycles 13–18 → counts 3/3 at 19; `qed_check_valid` first 1 at 19, 0 during 13–18.
- Issue and retire in the same cycle with inflight=1 → inflight stays 1. With `QED_INFLIGHT_CHECK_EN`, `qed_check_valid`=0 despite balanced counts.
- `CNT_W`=4, 16 orig retires → `qed_num_orig` holds 15; `qed_err`=1; `qed_check_valid` stays 0.
- `retire_valid` with inflight=0 → inflight stays 0. `qed_err`=1 only with `QED_INFLIGHT_CHECK_EN` defined.
